kuznechik_cipher_arbiter: RTL and testbench

KUZNECHIK_CIPHER_ARBITER -- requirements
Module: kuznechik_cipher_arbiter

---
 rtl/kuznechik_cipher_arbiter.sv | 110 +++++++++++
 tb/tb_kuznechik_cipher_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kuznechik_cipher_arbiter.sv
// rtl/kuznechik_cipher_arbiter.sv - two-requester round-robin front end for a Kuznechik core
// One block in flight; a WAIT watchdog soft-resets a hung core and returns an error result.
module kuznechik_cipher_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         resetn_i,
    input  logic [1:0]   req_valid_i,
    output logic [1:0]   req_ready_o,
    input  logic [127:0] req_data0_i,
    input  logic [127:0] req_data1_i,
    output logic [1:0]   rsp_valid_o,
    input  logic [1:0]   rsp_ready_i,
    output logic [127:0] rsp_data_o,
    output logic         rsp_err_o,
    output logic         core_req_o,
    output logic         core_ack_o,
    output logic [127:0] core_data_o,
    output logic         core_rstn_o,
    input  logic         core_busy_i,
    input  logic         core_valid_i,
    input  logic [127:0] core_data_i
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t       state_q;
    logic         last_grant_q;
    logic         owner_q;
    logic [127:0] blk_q;
    logic [127:0] res_q;
    logic         err_q;
    logic         ack_q;
    logic         soft_rst_q;
    logic [7:0]   cnt_q;

    logic grant_any;
    logic grant_idx;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant_any = |req_valid_i;
        grant_idx = (req_valid_i == 2'b11) ? ~last_grant_q : req_valid_i[1];
    end

    assign req_ready_o = (state_q == IDLE && resetn_i && grant_any) ?
                         (grant_idx ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid_o = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data_o  = res_q;
    assign rsp_err_o   = err_q;
    assign core_req_o  = (state_q == ISSUE) && !core_busy_i;
    assign core_ack_o  = ack_q;
    assign core_data_o = blk_q;
    assign core_rstn_o = resetn_i & ~soft_rst_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            blk_q        <= '0;
            res_q        <= '0;
            err_q        <= 1'b0;
            ack_q        <= 1'b0;
            soft_rst_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            ack_q      <= 1'b0;
            soft_rst_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        blk_q   <= grant_idx ? req_data1_i : req_data0_i;
                        owner_q <= grant_idx;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!core_busy_i) begin
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    // A result arriving on the last allowed cycle still beats the watchdog.
                    if (core_valid_i) begin
                        res_q   <= core_data_i;
                        err_q   <= 1'b0;
                        ack_q   <= 1'b1;
                        state_q <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        res_q      <= '0;
                        err_q      <= 1'b1;
                        soft_rst_q <= 1'b1;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i[owner_q]) begin
                        last_grant_q <= owner_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kuznechik_cipher_arbiter.sv
// tb/tb_kuznechik_cipher_arbiter.sv - random traffic against a cycle-level arbiter model and scoreboard
module tb_kuznechik_cipher_arbiter;
    localparam int TO = 8;

    logic         clk_i = 1'b0;
    logic         resetn_i;
    logic [1:0]   req_valid_i;
    logic [1:0]   req_ready_o;
    logic [127:0] req_data0_i;
    logic [127:0] req_data1_i;
    logic [1:0]   rsp_valid_o;
    logic [1:0]   rsp_ready_i;
    logic [127:0] rsp_data_o;
    logic         rsp_err_o;
    logic         core_req_o;
    logic         core_ack_o;
    logic [127:0] core_data_o;
    logic         core_rstn_o;
    logic         core_busy_i;
    logic         core_valid_i;
    logic [127:0] core_data_i;

    kuznechik_cipher_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_data0_i(req_data0_i), .req_data1_i(req_data1_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .core_req_o(core_req_o), .core_ack_o(core_ack_o),
        .core_data_o(core_data_o), .core_rstn_o(core_rstn_o),
        .core_busy_i(core_busy_i), .core_valid_i(core_valid_i),
        .core_data_i(core_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         owner;
        logic [127:0] data;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    int           m_phase = 0;
    logic         m_last  = 1'b1;
    logic [127:0] m_blk;
    int           m_d;
    int           m_req_cyc;
    int           m_resp_at;
    logic [1:0]   exp_ready;
    logic         w;
    exp_t         e;

    int   req_cnt = 0, req_lat = 0, ack_cnt = 0;
    int   acc_cnt[2];
    int   req_seen = 0, ack_seen = 0, cd = 0;
    int   acc_seen[2];
    logic force_hang = 1'b0;
    logic reached;
    logic [127:0] core_blk;

    function automatic logic [127:0] core_fn(input logic [127:0] x);
        return {x[63:0], x[127:64]} ^ 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic resp_checks(input logic first);
        chk("rsp_valid", 128'(rsp_valid_o), cur.owner ? 128'd2 : 128'd1);
        chk("rsp_data", rsp_data_o, cur.data);
        chk("rsp_err", 128'(rsp_err_o), 128'(cur.err));
        chk("core_ack", 128'(core_ack_o), 128'(first && !cur.err));
        chk("core_rstn", 128'(core_rstn_o), 128'(!(first && cur.err)));
        chk("req_ready_busy", 128'(req_ready_o), 128'd0);
        if (rsp_ready_i[cur.owner]) begin
            m_last  = cur.owner;
            m_phase = 0;
        end else begin
            m_phase = 3;
        end
    endtask

    task automatic quiet_checks();
        chk("rsp_valid_quiet", 128'(rsp_valid_o), 128'd0);
        chk("core_ack_quiet", 128'(core_ack_o), 128'd0);
        chk("core_rstn_quiet", 128'(core_rstn_o), 128'd1);
    endtask

    // Reference model: grant rule, issue on first non-busy cycle, result after min(latency, TIMEOUT)+1.
    always @(negedge clk_i) begin
        cyc++;
        if (!resetn_i) begin
            chk("rst_req_ready", 128'(req_ready_o), 128'd0);
            chk("rst_rsp_valid", 128'(rsp_valid_o), 128'd0);
            chk("rst_rsp_err", 128'(rsp_err_o), 128'd0);
            chk("rst_rsp_data", rsp_data_o, 128'd0);
            chk("rst_core_req", 128'(core_req_o), 128'd0);
            chk("rst_core_ack", 128'(core_ack_o), 128'd0);
            chk("rst_core_data", core_data_o, 128'd0);
            chk("rst_core_rstn", 128'(core_rstn_o), 128'd0);
            m_phase = 0;
            m_last  = 1'b1;
            exp_q.delete();
        end else begin
            if (core_ack_o) ack_cnt++;
            case (m_phase)
                0: begin
                    exp_ready = 2'b00;
                    w = 1'b0;
                    if (req_valid_i != 2'b00) begin
                        w = (req_valid_i == 2'b11) ? ~m_last : req_valid_i[1];
                        exp_ready = w ? 2'b10 : 2'b01;
                    end
                    chk("req_ready", 128'(req_ready_o), 128'(exp_ready));
                    chk("core_req_idle", 128'(core_req_o), 128'd0);
                    quiet_checks();
                    if (exp_ready != 2'b00) begin
                        m_blk   = w ? req_data1_i : req_data0_i;
                        m_d     = force_hang ? TO + 5 : int'($urandom_range(1, TO + 3));
                        e.owner = w;
                        e.err   = (m_d > TO);
                        e.data  = e.err ? 128'd0 : core_fn(m_blk);
                        exp_q.push_back(e);
                        acc_cnt[w]++;
                        m_phase = 1;
                    end
                end
                1: begin
                    chk("req_ready_issue", 128'(req_ready_o), 128'd0);
                    chk("core_data", core_data_o, m_blk);
                    chk("core_req_issue", 128'(core_req_o), 128'(!core_busy_i));
                    quiet_checks();
                    if (!core_busy_i) begin
                        m_phase   = 2;
                        m_req_cyc = cyc;
                        m_resp_at = cyc + ((m_d < TO) ? m_d : TO) + 1;
                        req_lat   = m_d;
                        req_cnt++;
                    end
                end
                2: begin
                    if (cyc < m_resp_at) begin
                        chk("req_ready_wait", 128'(req_ready_o), 128'd0);
                        chk("core_req_wait", 128'(core_req_o), 128'd0);
                        quiet_checks();
                    end else begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_err++;
                            $display("FAIL scoreboard_empty cycle=%0d actual=0 required=1", cyc);
                            m_phase = 0;
                        end else begin
                            cur = exp_q.pop_front();
                            resp_checks(1'b1);
                        end
                    end
                end
                default: resp_checks(1'b0);
            endcase
        end
    end

    task automatic drive();
        logic [1:0] v;
        v = req_valid_i;
        for (int i = 0; i < 2; i++) begin
            if (acc_cnt[i] != acc_seen[i]) begin
                acc_seen[i] = acc_cnt[i];
                v[i] = 1'($urandom_range(0, 1));
                if (v[i] && i == 0) req_data0_i = {$urandom, $urandom, $urandom, $urandom};
                if (v[i] && i == 1) req_data1_i = {$urandom, $urandom, $urandom, $urandom};
            end else if (v[i]) begin
                if ($urandom_range(0, 15) == 0) v[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                v[i] = 1'b1;
                if (i == 0) req_data0_i = {$urandom, $urandom, $urandom, $urandom};
                else        req_data1_i = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        req_valid_i = v;
        rsp_ready_i = 2'($urandom_range(0, 3));
        if (req_cnt != req_seen) begin
            req_seen = req_cnt;
            cd       = (req_lat <= TO) ? req_lat : 0;
            core_blk = core_data_o;
        end
        if (ack_cnt != ack_seen) begin
            ack_seen     = ack_cnt;
            core_valid_i = 1'b0;
        end
        if (cd == 1) begin
            core_valid_i = 1'b1;
            core_data_i  = core_fn(core_blk);
            cd = 0;
        end else if (cd > 1) begin
            cd--;
        end
        if (!core_valid_i) core_data_i = {$urandom, $urandom, $urandom, $urandom};
        core_busy_i = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        acc_cnt[0] = 0; acc_cnt[1] = 0; acc_seen[0] = 0; acc_seen[1] = 0;
        resetn_i = 1'b0; req_valid_i = 2'b00; req_data0_i = '0; req_data1_i = '0;
        rsp_ready_i = 2'b00; core_busy_i = 1'b0; core_valid_i = 1'b0; core_data_i = '0;
        repeat (3) @(posedge clk_i);
        #1 resetn_i = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk_i); #1;
            drive();
        end
        force_hang = 1'b1;
        reached = 1'b0;
        for (int k = 0; k < 300 && !reached; k++) begin
            @(posedge clk_i); #1;
            if (m_phase == 2 && m_d > TO && cyc >= m_req_cyc + 3) reached = 1'b1;
            else drive();
        end
        chk("reach_wait", 128'(reached), 128'd1);
        resetn_i = 1'b0;
        force_hang = 1'b0;
        req_valid_i = 2'b11;
        core_valid_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i); #1;
        cd = 0;
        req_seen = req_cnt;
        ack_seen = ack_cnt;
        acc_seen[0] = acc_cnt[0];
        acc_seen[1] = acc_cnt[1];
        resetn_i = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk_i); #1;
            drive();
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
